// File: rtl/rstmgr_crash_dump_reader.sv
// Streams a slot-indexed crash dump out over a valid/ready port: optional header word,
// then slots 0..cnt-1, one slot fetched per two cycles, last flagged on the final word.
//
// state | meaning
// IDLE  | waiting for start_i; busy_o low
// HDR   | presenting header word {Magic, pad, cnt}
// FETCH | slot_sel_o = idx, capturing slot_i into the data register
// SEND  | presenting captured slot word; last when idx == cnt-1
module rstmgr_crash_dump_reader #(
  parameter int          IdxWidth = 4,
  parameter int          RdWidth  = 32,
  parameter bit          HeaderEn = 1'b1,
  parameter logic [15:0] Magic    = 16'hC0DE
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [IdxWidth-1:0] slots_cnt_i,
  output logic [IdxWidth-1:0] slot_sel_o,
  input  logic [RdWidth-1:0]  slot_i,
  output logic [RdWidth-1:0]  data_o,
  output logic                valid_o,
  output logic                last_o,
  input  logic                ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_FETCH, ST_SEND} state_e;

  localparam logic [IdxWidth-1:0] IdxOne = {{(IdxWidth-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [IdxWidth-1:0] idx_q, idx_d;
  logic [IdxWidth-1:0] cnt_q, cnt_d;
  logic [IdxWidth-1:0] sel_q, sel_d;
  logic [RdWidth-1:0]  data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [RdWidth-1:0]  hdr_word;

  always_comb begin
    hdr_word = '0;
    hdr_word[RdWidth-1 -: 16] = Magic;
    hdr_word[IdxWidth-1:0] = slots_cnt_i;

    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    // Abort wins over any handshake in the same cycle; the word counts as not accepted.
    if (abort_i && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (slots_cnt_i == '0) begin
              err_d = 1'b1;
            end else begin
              cnt_d = slots_cnt_i;
              idx_d = '0;
              sel_d = '0;
              if (HeaderEn) begin
                state_d = ST_HDR;
                valid_d = 1'b1;
                data_d  = hdr_word;
                last_d  = 1'b0;
              end else begin
                state_d = ST_FETCH;
              end
            end
          end
        end
        ST_HDR: begin
          if (ready_i) begin
            state_d = ST_FETCH;
            valid_d = 1'b0;
          end
        end
        ST_FETCH: begin
          state_d = ST_SEND;
          data_d  = slot_i;
          valid_d = 1'b1;
          last_d  = (idx_q == cnt_q - IdxOne);
        end
        ST_SEND: begin
          if (ready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (last_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + IdxOne;
              sel_d   = idx_q + IdxOne;
              state_d = ST_FETCH;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign slot_sel_o = sel_q;
  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign last_o     = last_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_rstmgr_crash_dump_reader.sv
// Bench for the crash dump reader: one instance with header (index 1), one without (index 0),
// both reading the same store; accepted words are checked against the expected word sequence.
module tb_rstmgr_crash_dump_reader;

  logic        clk = 1'b0;
  logic        rst, start, abort, ready;
  logic [3:0]  cnt;
  logic [31:0] mem [16];
  logic [3:0]  sel_v  [2];
  logic [31:0] slot_v [2];
  logic [31:0] data_v [2];
  logic [1:0]  valid_v, last_v, busy_v, done_v, err_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign slot_v[0] = mem[sel_v[0]];
  assign slot_v[1] = mem[sel_v[1]];

  rstmgr_crash_dump_reader #(.HeaderEn(1'b1)) dut_hdr (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .slots_cnt_i(cnt),
    .slot_sel_o(sel_v[1]), .slot_i(slot_v[1]), .data_o(data_v[1]), .valid_o(valid_v[1]),
    .last_o(last_v[1]), .ready_i(ready), .busy_o(busy_v[1]), .done_o(done_v[1]), .err_o(err_v[1]));

  rstmgr_crash_dump_reader #(.HeaderEn(1'b0)) dut_nohdr (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .slots_cnt_i(cnt),
    .slot_sel_o(sel_v[0]), .slot_i(slot_v[0]), .data_o(data_v[0]), .valid_o(valid_v[0]),
    .last_o(last_v[0]), .ready_i(ready), .busy_o(busy_v[0]), .done_o(done_v[0]), .err_o(err_v[0]));

  // Reference: the dump is the word list [header if enabled] ++ mem[0..n-1].
  function automatic logic [31:0] exp_word(int d, int p, int n);
    if (d == 1) begin
      if (p == 0) return {16'hC0DE, 12'h000, 4'(n)};
      return mem[p-1];
    end
    return mem[p];
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; abort = 0; ready = 0; cnt = 0;
    fill_mem();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({valid_v[d], last_v[d], busy_v[d], done_v[d], err_v[d]} !== 5'b0 ||
          sel_v[d] !== 4'd0 || data_v[d] !== 32'd0) begin
        errors++;
        $display("FAIL reset dut%0d: v=%b l=%b b=%b dn=%b e=%b sel=%0d data=%h, required all 0",
                 d, valid_v[d], last_v[d], busy_v[d], done_v[d], err_v[d], sel_v[d], data_v[d]);
      end
    end
    rst = 0;
  endtask

  // rmode: 0 ready always 1, 1 random ready, 2 stall 5 cycles on slot 1 of header instance.
  // t6: change slots_cnt_i and pulse start while busy. ab: assert abort with start in IDLE.
  task automatic run_dump(input int n, input int rmode, input bit t6, input bit ab);
    int pos [2], dseen [2], lastk [2];
    bit hold [2];
    logic [31:0] pd [2];
    logic pl [2];
    int stall = 0;
    bit rdy;
    fill_mem();
    for (int d = 0; d < 2; d++) begin
      pos[d] = 0; dseen[d] = 0; lastk[d] = -1; hold[d] = 0; pd[d] = '0; pl[d] = 0;
    end
    @(negedge clk);
    cnt = 4'(n); start = 1; abort = ab; ready = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      abort = 0;
      start = (t6 && k == 3);
      cnt = (t6 && k >= 3) ? 4'd2 : 4'(n);
      if (rmode == 0) rdy = 1;
      else if (rmode == 1) rdy = 1'($urandom_range(0, 1));
      else if (valid_v[1] && pos[1] == 2 && stall < 5) begin rdy = 0; stall++; end
      else rdy = 1;
      ready = rdy;
      if (k == 1) begin
        checks++;
        if (busy_v !== 2'b11) begin
          errors++;
          $display("FAIL busy_after_start: busy=%b, required 11", busy_v);
        end
      end
      for (int d = 0; d < 2; d++) begin
        int total = n + d;
        if (hold[d]) begin
          checks++;
          if (data_v[d] !== pd[d] || last_v[d] !== pl[d] || valid_v[d] !== 1'b1) begin
            errors++;
            $display("FAIL stall_stable dut%0d: v=%b data=%h last=%b, required v=1 data=%h last=%b",
                     d, valid_v[d], data_v[d], last_v[d], pd[d], pl[d]);
          end
        end
        if (done_v[d]) begin
          checks++;
          if (pos[d] != total || dseen[d] != 0 || lastk[d] != k - 1 || busy_v[d] !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse dut%0d: words=%0d seen=%0d lastk=%0d k=%0d busy=%b, required words=%0d once at k=lastk+1 busy=0",
                     d, pos[d], dseen[d], lastk[d], k, busy_v[d], total);
          end
          dseen[d]++;
        end
        if (valid_v[d] && rdy) begin
          checks++;
          if (pos[d] >= total) begin
            errors++;
            $display("FAIL extra_word dut%0d: data=%h beyond %0d words", d, data_v[d], total);
          end else if (data_v[d] !== exp_word(d, pos[d], n) || last_v[d] !== (pos[d] == total - 1)) begin
            errors++;
            $display("FAIL word dut%0d #%0d: data=%h last=%b, required data=%h last=%b",
                     d, pos[d], data_v[d], last_v[d], exp_word(d, pos[d], n), pos[d] == total - 1);
          end
          pos[d]++;
          if (pos[d] == total) lastk[d] = k;
        end
        hold[d] = valid_v[d] && !rdy;
        pd[d] = data_v[d];
        pl[d] = last_v[d];
      end
      if (dseen[0] != 0 && dseen[1] != 0) break;
    end
    ready = 0; start = 0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pos[d] != n + d || dseen[d] != 1) begin
        errors++;
        $display("FAIL dump_complete dut%0d n=%0d: words=%0d done=%0d, required words=%0d done=1",
                 d, n, pos[d], dseen[d], n + d);
      end
    end
    if (rmode == 0) begin
      checks++;
      if (lastk[1] != 2 * n + 1 || lastk[0] != 2 * n) begin
        errors++;
        $display("FAIL latency n=%0d: hdr=%0d nohdr=%0d cycles, required %0d and %0d",
                 n, lastk[1], lastk[0], 2 * n + 1, 2 * n);
      end
    end
  endtask

  task automatic test_err();
    @(negedge clk);
    cnt = 0; start = 1; ready = 1;
    @(negedge clk);
    start = 0;
    checks++;
    if (err_v !== 2'b11 || busy_v !== 2'b00 || valid_v !== 2'b00) begin
      errors++;
      $display("FAIL err_pulse: err=%b busy=%b valid=%b, required 11 00 00", err_v, busy_v, valid_v);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (err_v !== 2'b00 || busy_v !== 2'b00 || valid_v !== 2'b00) begin
        errors++;
        $display("FAIL err_after: err=%b busy=%b valid=%b, required 00 00 00", err_v, busy_v, valid_v);
      end
    end
    ready = 0;
  endtask

  task automatic test_abort();
    fill_mem();
    @(negedge clk);
    cnt = 5; start = 1; ready = 1;
    @(negedge clk);
    start = 0;
    repeat (6) @(negedge clk);
    // Header instance is now presenting slot 2 with ready high.
    checks++;
    if (valid_v[1] !== 1'b1 || data_v[1] !== mem[2]) begin
      errors++;
      $display("FAIL abort_setup: v=%b data=%h, required v=1 data=%h", valid_v[1], data_v[1], mem[2]);
    end
    abort = 1;
    @(negedge clk);
    abort = 0;
    checks++;
    if (valid_v !== 2'b00 || busy_v !== 2'b00 || last_v !== 2'b00 || done_v !== 2'b00) begin
      errors++;
      $display("FAIL abort_idle: valid=%b busy=%b last=%b done=%b, required all 00",
               valid_v, busy_v, last_v, done_v);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (done_v !== 2'b00 || valid_v !== 2'b00) begin
        errors++;
        $display("FAIL abort_quiet: done=%b valid=%b, required 00 00", done_v, valid_v);
      end
    end
    ready = 0;
    run_dump(5, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    fill_mem();
    @(negedge clk);
    cnt = 4; start = 1; ready = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0; ready = 0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({valid_v[d], last_v[d], busy_v[d], done_v[d], err_v[d]} !== 5'b0 ||
          sel_v[d] !== 4'd0 || data_v[d] !== 32'd0) begin
        errors++;
        $display("FAIL reset_mid dut%0d: v=%b l=%b b=%b sel=%0d data=%h, required all 0",
                 d, valid_v[d], last_v[d], busy_v[d], sel_v[d], data_v[d]);
      end
    end
    run_dump(1, 0, 0, 0);
    checks++;
    if (sel_v[0] !== 4'd0 || sel_v[1] !== 4'd0) begin
      errors++;
      $display("FAIL single_sel: sel=%0d/%0d, required 0/0", sel_v[1], sel_v[0]);
    end
  endtask

  initial begin
    test_reset();
    run_dump(3, 0, 0, 0);       // basic dump, latency
    run_dump(3, 2, 0, 0);       // backpressure on slot 1
    test_err();
    test_abort();
    test_reset_mid();
    run_dump(5, 1, 1, 0);       // count change and start while busy
    run_dump(15, 1, 0, 0);      // maximum count
    run_dump(15, 0, 0, 0);
    repeat (4) run_dump($urandom_range(1, 15), 1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
